// File: rtl/keypad_scan_4x4_if.sv
// keypad_scan_4x4_if
//   Bundles the keypad matrix lines and the debounced key output of the
//   4x4 keypad scanner.
//
//   Signals:
//     row       [3:0]  keypad rows, active-low (driven by the keypad side)
//     col       [3:0]  column drive, active-low, one bit low at a time
//     key_code  [3:0]  hex value of the last accepted key
//     key_valid        one-cycle pulse when key_code is updated
//     key_held         high while the accepted key is still pressed
//
//   Modports:
//     slave   - the scanner (drives col and the key outputs)
//     master  - the keypad / consumer side (drives row)
interface keypad_scan_4x4_if;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    modport master (
        output row,
        input  col,
        input  key_code,
        input  key_valid,
        input  key_held
    );

    modport slave (
        input  row,
        output col,
        output key_code,
        output key_valid,
        output key_held
    );
endinterface

// File: rtl/keypad_scan_4x4.sv
// keypad_scan_4x4
//   Scans a 4x4 hex matrix keypad by driving one column low at a time,
//   samples the synchronised rows at the end of each column slot and
//   classifies every full scan as NONE, a single KEY or MULTI. A four-state
//   debounce FSM turns consecutive identical scan results into a clean key
//   code, a one-cycle key_valid pulse and a key_held level.
//
//   Ports:
//     clk   system clock
//     rst   asynchronous, active-high reset
//     kp    keypad_scan_4x4_if.slave (row in; col, key_code, key_valid,
//           key_held out)
//
//   Parameters:
//     SCAN_DIV        clk cycles each column is driven (>= 4)
//     DEBOUNCE_SCANS  identical full scans needed to accept press/release (>= 1)
//     REPEAT_SCANS    full scans between auto-repeat pulses
//
//   Optional feature macro: KEYPAD_AUTOREPEAT_EN
//     When defined, a held key re-pulses key_valid every REPEAT_SCANS scans.
module keypad_scan_4x4 #(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_SCANS   = 200
) (
    input logic              clk,
    input logic              rst,
    keypad_scan_4x4_if.slave kp
);

    typedef enum logic [1:0] {S_IDLE, S_DEB_PRESS, S_PRESSED, S_DEB_REL} state_t;
    typedef enum logic [1:0] {RES_NONE, RES_KEY, RES_MULTI} result_t;

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DEB_TARGET = CNT_W'(DEBOUNCE_SCANS);

    // Reject parameter values that would break the settle margin or debounce.
    if (SCAN_DIV < 4 || DEBOUNCE_SCANS < 1 || REPEAT_SCANS < 1) begin : g_badParams
        $error("keypad_scan_4x4: illegal parameter value");
    end

    logic [3:0]       r_sync1, r_sync2;
    logic [DIV_W-1:0] r_div;
    logic [1:0]       r_colIdx;
    logic             r_found, r_multi;
    logic [3:0]       r_accCode;
    state_t           r_state, w_nextState;
    logic [CNT_W-1:0] r_cnt, w_nextCnt, w_cntInc;
    logic [3:0]       r_cand, w_nextCand;
    logic [3:0]       r_keyCode;
    logic             r_keyValid;

    logic       w_slotEnd, w_scanEnd;
    logic [3:0] w_rowLow;
    logic       w_rowMany, w_rowOne;
    logic [1:0] w_rowIdx;
    logic [3:0] w_hitCode;
    logic       w_accFound, w_accMulti;
    logic [3:0] w_accCode;
    result_t    w_result;
    logic       w_accept, w_enterPressed, w_repeatHit;

    function automatic logic [3:0] keyMap(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
            4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
            4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
            4'hC: code = 4'h0;  4'hD: code = 4'hF;  4'hE: code = 4'hE;  default: code = 4'hD;
        endcase
        return code;
    endfunction

    // Two-flop synchroniser; idle rows read high because of the pull-ups.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 4'b1111;
            r_sync2 <= 4'b1111;
        end else begin
            r_sync1 <= kp.row;
            r_sync2 <= r_sync1;
        end
    end

    assign w_slotEnd = (r_div == DIV_LAST);
    assign w_scanEnd = w_slotEnd && (r_colIdx == 2'd3);

    // Row classification for the current column: x & (x-1) is nonzero only
    // when two or more rows are low at once.
    always_comb begin
        w_rowLow  = ~r_sync2;
        w_rowMany = (w_rowLow & (w_rowLow - 4'd1)) != 4'd0;
        w_rowOne  = (w_rowLow != 4'd0) && !w_rowMany;
        case (w_rowLow)
            4'b0010: w_rowIdx = 2'd1;
            4'b0100: w_rowIdx = 2'd2;
            4'b1000: w_rowIdx = 2'd3;
            default: w_rowIdx = 2'd0;
        endcase
        w_hitCode = keyMap(w_rowIdx, r_colIdx);

        // A second single hit in another column also makes the scan MULTI.
        w_accFound = r_found | w_rowOne;
        w_accMulti = r_multi | w_rowMany | (w_rowOne & r_found);
        w_accCode  = w_rowOne ? w_hitCode : r_accCode;

        if (w_accMulti)      w_result = RES_MULTI;
        else if (w_accFound) w_result = RES_KEY;
        else                 w_result = RES_NONE;
    end

    // Column slot timer plus the per-scan hit accumulator, which is cleared
    // at the end of column 3 once its result has been consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div     <= '0;
            r_colIdx  <= 2'd0;
            r_found   <= 1'b0;
            r_multi   <= 1'b0;
            r_accCode <= 4'h0;
        end else if (w_slotEnd) begin
            r_div    <= '0;
            r_colIdx <= r_colIdx + 2'd1;
            if (w_scanEnd) begin
                r_found   <= 1'b0;
                r_multi   <= 1'b0;
                r_accCode <= 4'h0;
            end else begin
                r_found   <= w_accFound;
                r_multi   <= w_accMulti;
                r_accCode <= w_accCode;
            end
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    // Debounce FSM next-state logic; it only moves on a scan-end cycle.
    always_comb begin
        w_nextState    = r_state;
        w_nextCnt      = r_cnt;
        w_nextCand     = r_cand;
        w_accept       = 1'b0;
        w_enterPressed = 1'b0;
        w_cntInc       = r_cnt + CNT_W'(1);
        if (w_scanEnd) begin
            case (r_state)
                S_IDLE: begin
                    if (w_result == RES_KEY) begin
                        w_nextCand = w_accCode;
                        if (DEBOUNCE_SCANS == 1) begin
                            w_nextState    = S_PRESSED;
                            w_nextCnt      = '0;
                            w_accept       = 1'b1;
                            w_enterPressed = 1'b1;
                        end else begin
                            w_nextState = S_DEB_PRESS;
                            w_nextCnt   = CNT_W'(1);
                        end
                    end
                end
                S_DEB_PRESS: begin
                    if (w_result == RES_KEY && w_accCode == r_cand) begin
                        if (w_cntInc == DEB_TARGET) begin
                            w_nextState    = S_PRESSED;
                            w_nextCnt      = '0;
                            w_accept       = 1'b1;
                            w_enterPressed = 1'b1;
                        end else begin
                            w_nextCnt = w_cntInc;
                        end
                    end else begin
                        w_nextState = S_IDLE;
                        w_nextCnt   = '0;
                    end
                end
                S_PRESSED: begin
                    if (w_result == RES_NONE) begin
                        if (DEBOUNCE_SCANS == 1) begin
                            w_nextState = S_IDLE;
                            w_nextCnt   = '0;
                        end else begin
                            w_nextState = S_DEB_REL;
                            w_nextCnt   = CNT_W'(1);
                        end
                    end
                end
                default: begin
                    if (w_result == RES_NONE) begin
                        if (w_cntInc == DEB_TARGET) begin
                            w_nextState = S_IDLE;
                            w_nextCnt   = '0;
                        end else begin
                            w_nextCnt = w_cntInc;
                        end
                    end else if (w_result == RES_KEY && w_accCode == r_cand) begin
                        w_nextState    = S_PRESSED;
                        w_nextCnt      = '0;
                        w_enterPressed = 1'b1;
                    end else begin
                        w_nextCnt = '0;
                    end
                end
            endcase
        end
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int REP_W = $clog2(REPEAT_SCANS + 1);
    localparam logic [REP_W-1:0] REP_TARGET = REP_W'(REPEAT_SCANS);
    logic [REP_W-1:0] r_repCnt;
    logic             w_repAdvance;

    assign w_repAdvance = w_scanEnd && (r_state == S_PRESSED) && (w_nextState == S_PRESSED);
    assign w_repeatHit  = w_repAdvance && ((r_repCnt + REP_W'(1)) == REP_TARGET);

    // Repeat counter runs only while steadily PRESSED; it freezes in DEB_REL.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_repCnt <= '0;
        end else if (w_enterPressed || w_repeatHit) begin
            r_repCnt <= '0;
        end else if (w_repAdvance) begin
            r_repCnt <= r_repCnt + REP_W'(1);
        end
    end
`else
    assign w_repeatHit = 1'b0;
`endif

    // State register and registered key outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_cand     <= 4'h0;
            r_keyCode  <= 4'h0;
            r_keyValid <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_cnt      <= w_nextCnt;
            r_cand     <= w_nextCand;
            r_keyValid <= w_accept | w_repeatHit;
            if (w_accept) begin
                r_keyCode <= w_nextCand;
            end
        end
    end

    assign kp.col       = ~(4'b0001 << r_colIdx);
    assign kp.key_code  = r_keyCode;
    assign kp.key_valid = r_keyValid;
    assign kp.key_held  = (r_state == S_PRESSED) || (r_state == S_DEB_REL);

endmodule

// File: tb/tb_keypad_scan_4x4.sv
// tb_keypad_scan_4x4
//   Self-checking bench for keypad_scan_4x4 with SCAN_DIV=4,
//   DEBOUNCE_SCANS=2, REPEAT_SCANS=3 (one full scan = 16 cycles).
//   A behavioural keypad pulls a row low while its column is driven low
//   and the corresponding bit of keyMask (bit r*4+c) is set.
module tb_keypad_scan_4x4;

    localparam int SCAN_DIV    = 4;
    localparam int DEB         = 2;
    localparam int REP         = 3;
    localparam int SCAN_CYCLES = 4 * SCAN_DIV;
`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int HOLD_PULSES = 4;
`else
    localparam int HOLD_PULSES = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] keyMask = 16'h0000;

    int compared   = 0;
    int mismatched = 0;
    int pulseCount = 0;

    keypad_scan_4x4_if kp();

    keypad_scan_4x4 #(
        .SCAN_DIV      (SCAN_DIV),
        .DEBOUNCE_SCANS(DEB),
        .REPEAT_SCANS  (REP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .kp (kp)
    );

    always #5 clk = ~clk;

    // Passive keypad matrix model.
    always_comb begin
        kp.row = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keyMask[r*4+c] && !kp.col[c]) kp.row[r] = 1'b0;
            end
        end
    end

    typedef struct {
        string       name;
        logic [15:0] mask;
        int          scans;
        int          expPulses;
        logic [3:0]  expCode;
        logic        expHeld;
    } vector_t;

    vector_t vec[20];

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
        if (kp.key_valid) pulseCount++;
    endtask

    task automatic applyStimulus(input logic [15:0] mask, input int scans);
        keyMask = mask;
        repeat (scans * SCAN_CYCLES) stepCycle();
    endtask

    initial begin
        // Key bits: 5=r1c1 (5), 3=r0c3 (A), 0=r0c0 (1), 15=r3c3 (D),
        // 10=r2c2 (9), 6=r1c2 (6), 14=r3c2 (E)
        vec[0]  = '{"press5_scan1",    16'h0020,  1, 0,           4'h0, 1'b0};
        vec[1]  = '{"press5_scan2",    16'h0020,  1, 1,           4'h5, 1'b1};
        vec[2]  = '{"rel5_scan1",      16'h0000,  1, 0,           4'h5, 1'b1};
        vec[3]  = '{"rel5_scan2",      16'h0000,  1, 0,           4'h5, 1'b0};
        vec[4]  = '{"bounceA_on1",     16'h0008,  1, 0,           4'h5, 1'b0};
        vec[5]  = '{"bounceA_off",     16'h0000,  1, 0,           4'h5, 1'b0};
        vec[6]  = '{"bounceA_on2",     16'h0008,  1, 0,           4'h5, 1'b0};
        vec[7]  = '{"bounceA_on3",     16'h0008,  1, 1,           4'hA, 1'b1};
        vec[8]  = '{"relA",            16'h0000,  2, 0,           4'hA, 1'b0};
        vec[9]  = '{"multi_1_D",       16'h8001,  2, 0,           4'hA, 1'b0};
        vec[10] = '{"multi_keep1",     16'h0001,  2, 1,           4'h1, 1'b1};
        vec[11] = '{"rel1",            16'h0000,  2, 0,           4'h1, 1'b0};
        vec[12] = '{"press9",          16'h0400,  2, 1,           4'h9, 1'b1};
        vec[13] = '{"glitch9_gap",     16'h0000,  1, 0,           4'h9, 1'b1};
        vec[14] = '{"glitch9_back",    16'h0400,  1, 0,           4'h9, 1'b1};
        vec[15] = '{"second_key_6",    16'h0440,  1, 0,           4'h9, 1'b1};
        vec[16] = '{"rel9",            16'h0000,  2, 0,           4'h9, 1'b0};
        vec[17] = '{"holdE",           16'h4000, 11, HOLD_PULSES, 4'hE, 1'b1};
        vec[18] = '{"relE",            16'h0000,  2, 0,           4'hE, 1'b0};
        vec[19] = '{"press5_again",    16'h0020,  2, 1,           4'h5, 1'b1};

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_col",   kp.col,       4'b1110);
        checkOutput("reset_code",  kp.key_code,  0);
        checkOutput("reset_valid", kp.key_valid, 0);
        checkOutput("reset_held",  kp.key_held,  0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            pulseCount = 0;
            applyStimulus(vec[i].mask, vec[i].scans);
            checkOutput({vec[i].name, "_pulses"}, pulseCount,     vec[i].expPulses);
            checkOutput({vec[i].name, "_code"},   kp.key_code,    vec[i].expCode);
            checkOutput({vec[i].name, "_held"},   kp.key_held,    vec[i].expHeld);
        end

        // Reset in the middle of a scan while key 5 is held and accepted.
        pulseCount = 0;
        repeat (7) stepCycle();
        checkOutput("midscan_col", kp.col, 4'b1101);
        rst = 1'b1;
        #1;
        checkOutput("async_col",   kp.col,       4'b1110);
        checkOutput("async_code",  kp.key_code,  0);
        checkOutput("async_valid", kp.key_valid, 0);
        checkOutput("async_held",  kp.key_held,  0);
        repeat (3) stepCycle();
        checkOutput("reset_no_pulse", pulseCount, 0);
        @(negedge clk);
        rst = 1'b0;
        pulseCount = 0;
        applyStimulus(16'h0020, 1);
        checkOutput("rearm_scan1_pulses", pulseCount, 0);
        checkOutput("rearm_scan1_held",   kp.key_held, 0);
        checkOutput("rearm_scan1_code",   kp.key_code, 0);
        applyStimulus(16'h0020, 1);
        checkOutput("rearm_scan2_pulses", pulseCount, 1);
        checkOutput("rearm_scan2_code",   kp.key_code, 5);
        checkOutput("rearm_scan2_held",   kp.key_held, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
